// File: rtl/mips_encoder.sv
// MIPS instruction encoder feeding a 2-entry {instr, addr} output FIFO; an accepted legal op is visible the next cycle.
// in_ready depends only on registered occupancy (drops when the FIFO is full); the head entry holds while out_ready is low.

module fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            // Storage is cleared so the head reads as zero straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module mips_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic [15:0] count
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    entry_t      push_ent;
    entry_t      head_ent;
    logic [31:0] enc_word;
    logic        legal;
    logic [31:0] next_addr;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (op)
            4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110};
            4'd5:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd6:    enc_word = {6'b001000, rs, rt, imm};
            4'd7:    enc_word = {6'b100011, rs, rt, imm};
            4'd8:    enc_word = {6'b101011, rs, rt, imm};
            4'd9:    enc_word = {6'b000100, rs, rt, imm};
            4'd10:   enc_word = {6'b000010, target};
            default: legal    = 1'b0;
        endcase
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign push_ent  = '{instr: enc_word, addr: next_addr};
    assign instr     = head_ent.instr;
    assign addr      = head_ent.addr;

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            // Illegal ops are consumed but never occupy an address slot.
            err <= accept && !legal;
            if (push) begin
                next_addr <= next_addr + 32'd4;
            end
            if (pop) begin
                count <= count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mips_encoder.sv
// Directed bench for mips_encoder; a second instance with a high BASE_ADDR covers address wrap.
module tb_mips_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_ready;

    logic        in_ready, out_valid, err;
    logic [31:0] instr, addr;
    logic [15:0] count;

    logic        in_ready2, out_valid2, err2;
    logic [31:0] instr2, addr2;
    logic [15:0] count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .addr(addr), .err(err), .count(count)
    );

    mips_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .out_valid(out_valid2), .out_ready(out_ready), .instr(instr2),
        .addr(addr2), .err(err2), .count(count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        op = o; rs = s; rt = t; rd = d; imm = i; target = tg;
        in_valid = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
        step(); step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (count !== 16'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if ({instr, addr} !== 64'd0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", instr, addr); end
    endtask

    task automatic test_single_add();
        apply_reset();
        out_ready = 1'b1;
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FF_FFFF);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (instr !== 32'h0022_1820) begin failures++; $display("FAIL add_instr got=%h exp=00221820", instr); end
        checks++; if (addr !== 32'd0) begin failures++; $display("FAIL add_addr got=%h exp=0", addr); end
        step();
        checks++; if (count !== 16'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill_stall();
        apply_reset();
        set_req(4'd7, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h0);
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready1 got=%b exp=1", in_ready); end
        set_req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready2 got=%b exp=0", in_ready); end
        set_req(4'd10, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h10);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        checks++; if ({instr, addr} !== {32'h8FA8_0004, 32'd0}) begin failures++; $display("FAIL stall_head got=%h@%h exp=8fa80004@0", instr, addr); end
        out_ready = 1'b1;
        step();
        checks++; if ({instr, addr} !== {32'h1022_FFFF, 32'd4}) begin failures++; $display("FAIL order_beq got=%h@%h exp=1022ffff@4", instr, addr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({instr, addr} !== {32'h0800_0010, 32'd8}) begin failures++; $display("FAIL order_j got=%h@%h exp=08000010@8", instr, addr); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%b exp=0", out_valid); end
        checks++; if (count !== 16'd3) begin failures++; $display("FAIL fill_count got=%0d exp=3", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        out_ready = 1'b1;
        set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_pulse got=%b exp=0", err); end
        set_req(4'd6, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
        step();
        in_valid = 1'b0;
        checks++; if ({instr, addr} !== {32'h2085_0010, 32'd0}) begin failures++; $display("FAIL illegal_next got=%h@%h exp=20850010@0", instr, addr); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_instr;
        apply_reset();
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd = 5'(i + 4);
            step();
            exp_instr = 32'h0022_0020 | (32'(i + 4) << 11);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || instr !== exp_instr ||
                addr !== 32'(4 * (i + 1)) || count !== 16'(i + 1)) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b r=%b %h@%h cnt=%0d exp v=1 r=1 %h@%h cnt=%0d",
                         i, out_valid, in_ready, instr, addr, count, exp_instr, 32'(4 * (i + 1)), i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (count !== 16'd11 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got cnt=%0d v=%b exp cnt=11 v=0", count, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        out_ready = 1'b1;
        set_req(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        set_req(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step(); step();
        checks++; if (in_ready !== 1'b0 || count !== 16'd1) begin failures++; $display("FAIL midrst_pre got r=%b cnt=%0d exp r=0 cnt=1", in_ready, count); end
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_flush got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        checks++; if (count !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
        set_req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        in_valid = 1'b0;
        checks++; if ({instr, addr} !== {32'h0022_1825, 32'd0}) begin failures++; $display("FAIL midrst_next got=%h@%h exp=00221825@0", instr, addr); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_addr_wrap();
        apply_reset();
        out_ready = 1'b1;
        set_req(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        checks++; if (addr2 !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_a0 got=%h exp=fffffff8", addr2); end
        set_req(4'd5, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        checks++; if ({instr2, addr2} !== {32'h0022_182A, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_a1 got=%h@%h exp=0022182a@fffffffc", instr2, addr2); end
        set_req(4'd8, 5'd3, 5'd9, 5'd0, 16'h0008, 26'h0);
        step();
        in_valid = 1'b0;
        checks++; if ({instr2, addr2} !== {32'hAC69_0008, 32'd0}) begin failures++; $display("FAIL wrap_a2 got=%h@%h exp=ac690008@0", instr2, addr2); end
        step();
        checks++; if (count2 !== 16'd3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", count2); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fill_stall();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        test_addr_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
